// File: rtl/io_arbiter.sv
// Arbitrates a CPU write queue and a debug request port onto one peripheral bus,
// with round-robin fairness and a per-transaction ready timeout.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no bus transaction; chooses next requester (round-robin)
// CPU_XFER | bus driven from queue head; pops on completion or timeout
// DBG_XFER | bus driven from dbg_* inputs; pulses dbg_gnt on completion/timeout
module io_arbiter #(
   parameter int FIFO_DEPTH = 4,
   parameter int WAIT_MAX   = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_base,
   input  logic [15:0] cpu_data,
   input  logic        cpu_flag,
   output logic        cpu_full,
   output logic        cpu_ovf,
   input  logic        dbg_req,
   input  logic [15:0] dbg_addr,
   input  logic [15:0] dbg_wdata,
   input  logic        dbg_we,
   output logic        dbg_gnt,
   output logic [15:0] dbg_rdata,
   output logic        dbg_rvalid,
   output logic        bus_valid,
   output logic [15:0] bus_addr,
   output logic [15:0] bus_wdata,
   output logic        bus_we,
   output logic        bus_src,
   input  logic        bus_ready,
   input  logic [15:0] bus_rdata,
   output logic        bus_err
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_MAX - 1);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] CPU_XFER = 2'd1;
   localparam logic [1:0] DBG_XFER = 2'd2;

   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [31:0]   head;

   logic [1:0]    state;
   logic          last_src;
   logic [CW-1:0] wait_cnt;

   logic push;
   logic drop;
   logic pop;
   logic in_xfer;
   logic xfer_done;
   logic xfer_abort;
   logic xfer_end;
   logic cpu_pend;
   logic dbg_pend;

   assign cpu_full   = (count == DEPTH_CNT);
   assign head       = mem[rd_ptr];
   assign push       = cpu_flag & ~cpu_full;
   assign drop       = cpu_flag & cpu_full;
   assign in_xfer    = (state == CPU_XFER) | (state == DBG_XFER);
   assign xfer_done  = in_xfer & bus_ready;
   assign xfer_abort = in_xfer & ~bus_ready & (wait_cnt == '0);
   assign xfer_end   = xfer_done | xfer_abort;
   assign pop        = (state == CPU_XFER) & xfer_end;
   assign cpu_pend   = (count != '0);
   // dbg_req may still be high during the grant cycle; don't serve it twice
   assign dbg_pend   = dbg_req & ~dbg_gnt;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cpu_base, cpu_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_src   <= 1'b1;
         wait_cnt   <= '0;
         bus_valid  <= 1'b0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         bus_we     <= 1'b0;
         bus_src    <= 1'b0;
         dbg_gnt    <= 1'b0;
         dbg_rvalid <= 1'b0;
         dbg_rdata  <= '0;
         cpu_ovf    <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         dbg_gnt    <= 1'b0;
         dbg_rvalid <= 1'b0;
         if (drop) cpu_ovf <= 1'b1;
         case (state)
            IDLE: begin
               if (cpu_pend && (!dbg_pend || last_src)) begin
                  state     <= CPU_XFER;
                  bus_valid <= 1'b1;
                  bus_addr  <= head[31:16];
                  bus_wdata <= head[15:0];
                  bus_we    <= 1'b1;
                  bus_src   <= 1'b0;
                  wait_cnt  <= WAIT_LOAD;
               end else if (dbg_pend) begin
                  state     <= DBG_XFER;
                  bus_valid <= 1'b1;
                  bus_addr  <= dbg_addr;
                  bus_wdata <= dbg_wdata;
                  bus_we    <= dbg_we;
                  bus_src   <= 1'b1;
                  wait_cnt  <= WAIT_LOAD;
               end
            end
            CPU_XFER, DBG_XFER: begin
               if (xfer_end) begin
                  state     <= IDLE;
                  bus_valid <= 1'b0;
                  last_src  <= (state == DBG_XFER);
                  if (xfer_abort) bus_err <= 1'b1;
                  if (state == DBG_XFER) begin
                     dbg_gnt <= 1'b1;
                     if (xfer_done && !bus_we) begin
                        dbg_rvalid <= 1'b1;
                        dbg_rdata  <= bus_rdata;
                     end
                  end
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               bus_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io_arbiter.sv
// Directed bench for io_arbiter: expected bus transactions and debug grants are
// queued by the stimulus and checked by a negedge monitor.
module tb_io_arbiter;

   localparam int FIFO_DEPTH = 4;
   localparam int WAIT_MAX   = 15;

   logic        clk;
   logic        reset;
   logic [15:0] cpu_base, cpu_data;
   logic        cpu_flag, cpu_full, cpu_ovf;
   logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
   logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic        bus_valid, bus_we, bus_src, bus_ready, bus_err;
   logic [15:0] bus_addr, bus_wdata, bus_rdata;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] wdata;
      logic        we;
      logic        src;
   } bus_t;

   typedef struct packed {
      logic        rvalid;
      logic [15:0] rdata;
   } dbg_t;

   bus_t exp_bus[$];
   dbg_t exp_dbg[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic prev_valid = 1'b0;

   io_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .WAIT_MAX(WAIT_MAX)) dut (
      .clk(clk), .reset(reset),
      .cpu_base(cpu_base), .cpu_data(cpu_data), .cpu_flag(cpu_flag),
      .cpu_full(cpu_full), .cpu_ovf(cpu_ovf),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_we(dbg_we),
      .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
      .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_we(bus_we), .bus_src(bus_src), .bus_ready(bus_ready),
      .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_bus(input logic [15:0] a, input logic [15:0] w, input logic we, input logic src);
      bus_t t;
      t.addr = a; t.wdata = w; t.we = we; t.src = src;
      exp_bus.push_back(t);
   endtask

   task automatic push_dbg(input logic rv, input logic [15:0] rd);
      dbg_t t;
      t.rvalid = rv; t.rdata = rd;
      exp_dbg.push_back(t);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_gnt(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         tick();
         if (dbg_gnt) seen = 1'b1;
      end
      check({name, "_gnt_seen"}, seen, 1'b1);
   endtask

   task automatic wait_drain(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 80 && !done; i++) begin
         tick();
         if (exp_bus.size() == 0 && !bus_valid) done = 1'b1;
      end
      check({name, "_drained"}, done, 1'b1);
   endtask

   // Scoreboard monitor: each new bus request and each debug grant consumes one expectation
   always @(negedge clk) begin
      if (!reset && bus_valid && !prev_valid) begin
         if (exp_bus.size() == 0) begin
            check("bus_unexpected", 1'b1, 1'b0);
         end else begin
            bus_t e;
            e = exp_bus.pop_front();
            check("bus_xfer", {bus_addr, bus_wdata, bus_we, bus_src}, {e.addr, e.wdata, e.we, e.src});
         end
      end
      if (!reset && dbg_gnt) begin
         if (exp_dbg.size() == 0) begin
            check("dbg_unexpected", 1'b1, 1'b0);
         end else begin
            dbg_t d;
            d = exp_dbg.pop_front();
            check("dbg_rvalid", dbg_rvalid, d.rvalid);
            if (d.rvalid) check("dbg_rdata", dbg_rdata, d.rdata);
         end
      end
      prev_valid <= bus_valid;
   end

   initial begin
      int vcount, gcount;
      reset = 1'b1; cpu_flag = 1'b0; cpu_base = '0; cpu_data = '0;
      dbg_req = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_we = 1'b0;
      bus_ready = 1'b0; bus_rdata = '0;

      // reset state
      tick(); tick();
      check("rst_bus_valid", bus_valid, 1'b0);
      check("rst_cpu_full", cpu_full, 1'b0);
      check("rst_cpu_ovf", cpu_ovf, 1'b0);
      check("rst_bus_err", bus_err, 1'b0);
      check("rst_dbg_gnt", dbg_gnt, 1'b0);
      check("rst_dbg_rvalid", dbg_rvalid, 1'b0);
      check("rst_dbg_rdata", dbg_rdata, 16'h0000);
      check("rst_bus_addr", bus_addr, 16'h0000);
      reset = 1'b0;
      tick();

      // single CPU write, ready tied high: latency and one-cycle request
      bus_ready = 1'b1;
      cpu_flag = 1'b1; cpu_base = 16'h0001; cpu_data = 16'h000A;
      push_bus(16'h0001, 16'h000A, 1'b1, 1'b0);
      tick();
      cpu_flag = 1'b0;
      check("lat_after_push", bus_valid, 1'b0);
      tick();
      check("lat_valid", bus_valid, 1'b1);
      tick();
      check("lat_one_cycle", bus_valid, 1'b0);
      tick(); tick();

      // overflow: five pushes with ready low, then drain four in order
      bus_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cpu_flag = 1'b1;
         cpu_base = 16'(16'h0100 + i);
         cpu_data = 16'(16'h0200 + i);
         if (i < 4) push_bus(16'(16'h0100 + i), 16'(16'h0200 + i), 1'b1, 1'b0);
         tick();
         if (i == 3) begin
            check("full_after_4", cpu_full, 1'b1);
            check("ovf_after_4", cpu_ovf, 1'b0);
         end
      end
      cpu_flag = 1'b0;
      check("full_after_5", cpu_full, 1'b1);
      check("ovf_after_5", cpu_ovf, 1'b1);
      bus_ready = 1'b1;
      wait_drain("ovf");
      tick(); tick();
      check("ovf_not_full", cpu_full, 1'b0);
      check("ovf_no_err", bus_err, 1'b0);

      // round-robin alternation: CPU, debug, CPU
      do_reset();
      check("rr_ovf_cleared", cpu_ovf, 1'b0);
      bus_ready = 1'b1;
      cpu_flag = 1'b1; cpu_base = 16'h0300; cpu_data = 16'h0030;
      push_bus(16'h0300, 16'h0030, 1'b1, 1'b0);
      push_bus(16'h0400, 16'h5555, 1'b1, 1'b1);
      push_bus(16'h0301, 16'h0031, 1'b1, 1'b0);
      push_dbg(1'b0, 16'h0000);
      tick();
      cpu_base = 16'h0301; cpu_data = 16'h0031;
      dbg_req = 1'b1; dbg_addr = 16'h0400; dbg_wdata = 16'h5555; dbg_we = 1'b1;
      tick();
      cpu_flag = 1'b0;
      wait_gnt("rr");
      dbg_req = 1'b0;
      wait_drain("rr");
      tick(); tick();

      // debug read, ready after three cycles
      bus_ready = 1'b0;
      dbg_req = 1'b1; dbg_addr = 16'h0010; dbg_wdata = 16'h1234; dbg_we = 1'b0;
      push_bus(16'h0010, 16'h1234, 1'b0, 1'b1);
      push_dbg(1'b1, 16'hBEEF);
      repeat (3) tick();
      bus_ready = 1'b1; bus_rdata = 16'hBEEF;
      wait_gnt("rd");
      check("rd_rvalid", dbg_rvalid, 1'b1);
      check("rd_rdata", dbg_rdata, 16'hBEEF);
      dbg_req = 1'b0; bus_ready = 1'b0;
      tick(); tick();

      // timeout abort on a debug read
      check("err_pre", bus_err, 1'b0);
      dbg_req = 1'b1; dbg_addr = 16'h0020; dbg_wdata = 16'h0BAD; dbg_we = 1'b0;
      push_bus(16'h0020, 16'h0BAD, 1'b0, 1'b1);
      push_dbg(1'b0, 16'h0000);
      vcount = 0; gcount = 0;
      for (int i = 0; i < WAIT_MAX + 2; i++) begin
         tick();
         if (bus_valid) vcount++;
         if (dbg_gnt) begin
            gcount++;
            check("to_rvalid", dbg_rvalid, 1'b0);
            dbg_req = 1'b0;
         end
      end
      dbg_req = 1'b0;
      check("to_valid_cycles", vcount, WAIT_MAX);
      check("to_gnt_count", gcount, 1);
      check("to_bus_err", bus_err, 1'b1);
      tick();

      // reset mid CPU transfer with two entries queued
      do_reset();
      check("mid_err_cleared", bus_err, 1'b0);
      bus_ready = 1'b0;
      cpu_flag = 1'b1; cpu_base = 16'h0600; cpu_data = 16'h0060;
      push_bus(16'h0600, 16'h0060, 1'b1, 1'b0);
      tick();
      cpu_base = 16'h0601; cpu_data = 16'h0061;
      tick();
      cpu_flag = 1'b0;
      tick();
      check("mid_in_xfer", bus_valid, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_valid_low", bus_valid, 1'b0);
      check("mid_not_full", cpu_full, 1'b0);
      bus_ready = 1'b1;
      vcount = 0;
      repeat (10) begin
         tick();
         if (bus_valid) vcount++;
      end
      check("mid_no_more_xfers", vcount, 0);
      check("mid_no_gnt", dbg_gnt, 1'b0);

      check("left_bus", exp_bus.size(), 0);
      check("left_dbg", exp_dbg.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/io_arbiter.md
IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the CPU write-queue depth in entries (power of two, 2..16).
REQ-002 Parameter WAIT_MAX, default 15, SHALL set the number of cycles a bus transaction may wait for bus_ready before it is aborted.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cpu_base  in  16  CPU port address, sampled when cpu_flag=1.
REQ-006 cpu_data  in  16  CPU write data, sampled when cpu_flag=1.
REQ-007 cpu_flag  in  1  CPU OUT strobe; each high cycle is one write request.
REQ-008 cpu_full  out  1  write queue holds FIFO_DEPTH entries.
REQ-009 cpu_ovf  out  1  sticky: a CPU write was dropped.
REQ-010 dbg_req  in  1  debug-port request; held high until dbg_gnt.
REQ-011 dbg_addr  in  16  debug port address; stable while dbg_req=1.
REQ-012 dbg_wdata  in  16  debug write data; stable while dbg_req=1.
REQ-013 dbg_we  in  1  1=write, 0=read; stable while dbg_req=1.
REQ-014 dbg_gnt  out  1  one-cycle pulse: debug transaction completed or aborted.
REQ-015 dbg_rdata  out  16  read data, valid when dbg_rvalid=1.
REQ-016 dbg_rvalid  out  1  one-cycle pulse, concurrent with dbg_gnt, on a successful debug read.
REQ-017 bus_valid, bus_addr[16], bus_wdata[16], bus_we, bus_src  out  peripheral bus request; bus_src 0=CPU, 1=debug.
REQ-018 bus_ready  in  1, bus_rdata  in  16  peripheral completion and read data.
REQ-019 bus_err  out  1  sticky: a bus transaction timed out.

Function
REQ-020 A cpu_flag high cycle with cpu_full=0 SHALL push {cpu_base,cpu_data} at that edge; with cpu_full=1 it SHALL be dropped and cpu_ovf set, even if a pop occurs in the same cycle.
REQ-021 A simultaneous push and pop on a non-full queue SHALL leave the count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 FSM states IDLE, CPU_XFER, DBG_XFER; each transaction SHALL pass through IDLE for at least one cycle.
REQ-023 In IDLE with the queue non-empty and dbg_req=0, the FSM SHALL enter CPU_XFER; with dbg_req=1 and the queue empty, it SHALL enter DBG_XFER.
REQ-024 When both are pending in IDLE, the requester not served last SHALL win (round-robin bit last_src; 0=CPU, 1=debug).
REQ-025 On entering a XFER state, bus_addr/bus_wdata/bus_we/bus_src SHALL be loaded from the queue head (bus_we=1) or the dbg_* inputs, and bus_valid=1; these SHALL be held stable until completion.
REQ-026 Completion SHALL occur on the first cycle in a XFER state with bus_ready=1: bus_valid drops next cycle, last_src is updated, and the FSM returns to IDLE.
REQ-027 CPU completion SHALL pop the queue head; debug completion SHALL pulse dbg_gnt and, for reads, capture bus_rdata into dbg_rdata and pulse dbg_rvalid.
REQ-028 A wait counter SHALL clear on XFER entry; if bus_ready is still 0 after WAIT_MAX XFER cycles, the transaction SHALL abort: bus_err set, CPU entry popped or dbg_gnt pulsed without dbg_rvalid, FSM to IDLE.
REQ-029 Latency: cpu_flag at edge N into an empty queue with FSM idle SHALL yield bus_valid=1 from cycle N+2.
REQ-030 bus_ready while bus_valid=0 SHALL be ignored.

Reset
REQ-031 With reset high at a clock edge, all outputs SHALL be 0, the queue emptied, the FSM set to IDLE, last_src set to 1, and cpu_ovf/bus_err cleared.
REQ-032 Reset mid-transaction SHALL abort without dbg_gnt or a pop; queued entries SHALL be discarded.

Verification
REQ-033 Single CPU write base=0x0001, data=0x000A, bus_ready tied 1 -> bus_valid high cycle N+2 for one cycle, addr 0x0001, wdata 0x000A, we=1, src=0.
REQ-034 Five back-to-back cpu_flag pulses, bus_ready=0 -> cpu_full=1 after the 4th, 5th dropped, cpu_ovf=1; releasing ready drains exactly 4 writes in push order.
REQ-035 CPU queue non-empty and dbg_req held together after reset -> CPU first, debug second, CPU third (alternation).
REQ-036 Debug read addr 0x0010, bus_ready after 3 cycles with bus_rdata=0xBEEF -> dbg_gnt and dbg_rvalid pulse together, dbg_rdata=0xBEEF.
REQ-037 bus_ready held 0 for WAIT_MAX+2 cycles -> abort after WAIT_MAX cycles, bus_err=1, dbg_gnt pulses with dbg_rvalid=0.
REQ-038 Reset asserted during CPU_XFER with 2 entries queued -> next cycle bus_valid=0, cpu_full=0, no further bus transactions.
